// File: rtl/servo_ramp_ctrl_if.sv
// servo_ramp_ctrl_if: command handshake and PWM-facing outputs of the servo ramp controller
interface servo_ramp_ctrl_if;
  logic       cmd_valid;
  logic [9:0] cmd_pos;
  logic       cmd_ready;
  logic [11:0] pw_us;
  logic       frame_start;
  logic       busy;
  logic       done;
  modport master (output cmd_valid, cmd_pos, input cmd_ready, pw_us, frame_start, busy, done);
  modport slave (input cmd_valid, cmd_pos, output cmd_ready, pw_us, frame_start, busy, done);
endinterface

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: maps position commands to pulse-width targets and slews pw_us
// toward them by at most STEP_MAX us per servo frame.
module servo_ramp_ctrl #(
  parameter int TICK_DIV = 50,
  parameter int FRAME_US = 20000,
  parameter int PW_MIN   = 500,
  parameter int PW_MAX   = 2500,
  parameter int STEP_MAX = 10
) (
  input logic clk,
  input logic rst_a,
  servo_ramp_ctrl_if.slave bus
);
  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam int FRM_W = $clog2(FRAME_US + 1);
  localparam logic [11:0] PW_MID = 12'((PW_MIN + PW_MAX) / 2);
  typedef enum logic [1:0] {IDLE, CALC, RAMP} state_t;
  state_t state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic fs_q, fs_d, done_q, done_d;
  logic [9:0] pos_q, pos_d;
  logic [11:0] tgt_q, tgt_d, pw_q, pw_d, gap, step, calc_tgt;
  logic [31:0] prod;
  logic tick, up, accept;
  always_comb begin
    tick = pre_q == PRE_W'(TICK_DIV - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    frm_d = tick ? (frm_q == FRM_W'(FRAME_US - 1) ? '0 : frm_q + 1'b1) : frm_q;
    fs_d = tick && frm_q == FRM_W'(FRAME_US - 1);
    up = pw_q < tgt_q;
    gap = up ? tgt_q - pw_q : pw_q - tgt_q;
    step = gap > 12'(STEP_MAX) ? 12'(STEP_MAX) : gap;
    pw_d = fs_q ? (up ? pw_q + step : pw_q - step) : pw_q;
    prod = 32'(pos_q) * 32'(PW_MAX - PW_MIN);
    calc_tgt = 12'(32'(PW_MIN) + prod / 32'd1023);
    accept = bus.cmd_valid && state_q != CALC;
    pos_d = accept ? bus.cmd_pos : pos_q;
    state_d = state_q;
    tgt_d = tgt_q;
    done_d = 1'b0;
    // A frame step in CALC still follows the old target; CALC alone decides the outcome.
    if (state_q == CALC) begin
      tgt_d = calc_tgt;
      done_d = calc_tgt == pw_d;
      state_d = calc_tgt == pw_d ? IDLE : RAMP;
    end else if (accept) begin
      state_d = CALC;
    end else if (state_q == RAMP && fs_q && pw_d == tgt_q) begin
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q <= IDLE;
      pre_q <= '0;
      frm_q <= '0;
      fs_q <= 1'b0;
      done_q <= 1'b0;
      pos_q <= '0;
      tgt_q <= PW_MID;
      pw_q <= PW_MID;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      frm_q <= frm_d;
      fs_q <= fs_d;
      done_q <= done_d;
      pos_q <= pos_d;
      tgt_q <= tgt_d;
      pw_q <= pw_d;
    end
  end
  assign bus.cmd_ready = state_q != CALC;
  assign bus.busy = state_q != IDLE;
  assign bus.pw_us = pw_q;
  assign bus.frame_start = fs_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl: directed checks of the servo ramp controller with a 20-clk frame,
// one instance at STEP_MAX=10 and one at STEP_MAX=7.
module tb_servo_ramp_ctrl;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  int checks = 0;
  int errors = 0;
  servo_ramp_ctrl_if ia ();
  servo_ramp_ctrl_if ib ();
  servo_ramp_ctrl #(.TICK_DIV(2), .FRAME_US(10), .STEP_MAX(10)) dut_a (.clk(clk), .rst_a(rst_a), .bus(ia));
  servo_ramp_ctrl #(.TICK_DIV(2), .FRAME_US(10), .STEP_MAX(7)) dut_b (.clk(clk), .rst_a(rst_a), .bus(ib));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_fs(input bit use_b);
    int n = 0;
    while (!(use_b ? ib.frame_start : ia.frame_start) && n < 100) begin
      tick(1);
      n++;
    end
    chk("frame_start_seen", use_b ? ib.frame_start : ia.frame_start, 1);
  endtask
  initial begin
    ia.cmd_valid = 1'b0;
    ia.cmd_pos = '0;
    ib.cmd_valid = 1'b0;
    ib.cmd_pos = '0;
    tick(2);
    chk("rst_pw", ia.pw_us, 1500);
    chk("rst_ready", ia.cmd_ready, 1);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_fs", ia.frame_start, 0);
    rst_a = 1'b0;
    tick(19);
    chk("fs_before_first", ia.frame_start, 0);
    tick(1);
    chk("fs_first", ia.frame_start, 1);
    tick(1);
    chk("fs_one_clk", ia.frame_start, 0);
    tick(18);
    chk("fs_before_second", ia.frame_start, 0);
    tick(1);
    chk("fs_second", ia.frame_start, 1);
    // ramp 1500 -> 2500 in steps of 10
    ia.cmd_valid = 1'b1;
    ia.cmd_pos = 10'd1023;
    tick(1);
    ia.cmd_valid = 1'b0;
    chk("calc_ready", ia.cmd_ready, 0);
    chk("calc_busy", ia.busy, 1);
    tick(1);
    chk("ramp_busy", ia.busy, 1);
    chk("ramp_ready", ia.cmd_ready, 1);
    chk("ramp_pw_hold", ia.pw_us, 1500);
    for (int i = 1; i <= 100; i++) begin
      wait_fs(0);
      tick(1);
      chk("ramp_up_pw", ia.pw_us, 32'(1500 + 10 * i));
      chk("ramp_up_done", ia.done, 32'(i == 100));
    end
    chk("top_busy", ia.busy, 0);
    tick(1);
    chk("done_one_clk", ia.done, 0);
    // STEP_MAX=7: same-target command, then ramp down to 500
    ib.cmd_valid = 1'b1;
    ib.cmd_pos = 10'd512;
    tick(1);
    ib.cmd_valid = 1'b0;
    chk("b_calc_ready", ib.cmd_ready, 0);
    chk("b_calc_pw", ib.pw_us, 1500);
    tick(1);
    chk("b_mid_done", ib.done, 1);
    chk("b_mid_busy", ib.busy, 0);
    chk("b_mid_pw", ib.pw_us, 1500);
    tick(1);
    chk("b_mid_done_clr", ib.done, 0);
    ib.cmd_valid = 1'b1;
    ib.cmd_pos = 10'd0;
    tick(1);
    ib.cmd_valid = 1'b0;
    tick(1);
    chk("b_down_busy", ib.busy, 1);
    for (int i = 1; i <= 143; i++) begin
      wait_fs(1);
      tick(1);
      chk("b_down_pw", ib.pw_us, (1500 - 7 * i < 500) ? 32'd500 : 32'(1500 - 7 * i));
      chk("b_down_done", ib.done, 32'(i == 143));
    end
    chk("b_bottom_busy", ib.busy, 0);
    // retarget mid-ramp after a clean reset
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    ia.cmd_valid = 1'b1;
    ia.cmd_pos = 10'd1023;
    tick(1);
    ia.cmd_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wait_fs(0);
      tick(1);
    end
    chk("rt_pw_1600", ia.pw_us, 1600);
    ia.cmd_valid = 1'b1;
    ia.cmd_pos = 10'd0;
    tick(1);
    ia.cmd_valid = 1'b0;
    chk("rt_ready_low", ia.cmd_ready, 0);
    tick(1);
    chk("rt_ready_back", ia.cmd_ready, 1);
    chk("rt_pw_hold", ia.pw_us, 1600);
    wait_fs(0);
    tick(1);
    chk("rt_reverse", ia.pw_us, 1590);
    chk("rt_busy", ia.busy, 1);
    // accept coincident with frame_start; valid held through CALC
    wait_fs(0);
    ia.cmd_valid = 1'b1;
    ia.cmd_pos = 10'd1023;
    tick(1);
    chk("sim_old_target_step", ia.pw_us, 1580);
    chk("sim_calc_ready", ia.cmd_ready, 0);
    tick(1);
    ia.cmd_valid = 1'b0;
    chk("sim_not_reaccepted", ia.cmd_ready, 1);
    chk("sim_busy", ia.busy, 1);
    tick(1);
    chk("sim_still_ready", ia.cmd_ready, 1);
    wait_fs(0);
    tick(1);
    chk("sim_new_dir", ia.pw_us, 1590);
    // asynchronous reset between edges mid-ramp
    tick(3);
    #2;
    rst_a = 1'b1;
    #1;
    chk("arst_pw", ia.pw_us, 1500);
    chk("arst_busy", ia.busy, 0);
    chk("arst_ready", ia.cmd_ready, 1);
    #1;
    rst_a = 1'b0;
    tick(19);
    chk("arst_fs_before", ia.frame_start, 0);
    tick(1);
    chk("arst_fs_first", ia.frame_start, 1);
    tick(1);
    chk("arst_pw_stays", ia.pw_us, 1500);
    chk("arst_idle", ia.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
